fp_mult_sequencer: RTL and testbench
====================================

Name: fp_mult_sequencer

Overview:
- Issue/retire stage wrapped around the combinational FP_Multiplicator in the FPU datapath.
- Accepts an operand pair and destination register from FP register-file read with a valid/ready handshake.
- Holds the operands stable on the multiplier inputs for a configurable multicycle window, then captures the product and exception bits.
- Presents the captured result to FP writeback with valid/ready, and keeps sticky overflow/underflow status flags for the FP control/status register.

Parameters:
- MUL_CYCLES, 2, cycles operands are held on the multiplier before the result is captured; legal range 1..15.
- DEST_W, 5, width of the FP destination register index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  sequencer can accept an operand pair this cycle.
- in_a  in  32  operand A, IEEE-754 single.
- in_b  in  32  operand B, IEEE-754 single.
- in_dest  in  DEST_W  destination FP register index.
- mul_a  out  32  to FP_Multiplicator input a.
- mul_b  out  32  to FP_Multiplicator input b.
- mul_result  in  32  from FP_Multiplicator result.
- mul_overflow  in  1  from FP_Multiplicator overflow.
- mul_underflow  in  1  from FP_Multiplicator underflow.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts the result.
- out_result  out  32  captured product.
- out_dest  out  DEST_W  captured destination index.
- out_overflow  out  1  overflow flag of this result.
- out_underflow  out  1  underflow flag of this result.
- flags_clear  in  1  clears the sticky flags.
- flag_overflow  out  1  sticky overflow flag.
- flag_underflow  out  1  sticky underflow flag.
- busy  out  1  high in EXEC or DONE.

Behaviour:
- Reset (synchronous, checked at the rising edge, overrides everything):
  - state=IDLE; counter=0.
  - Operand registers 0, so mul_a=mul_b=0.
  - out_result=0, out_dest=0, out_overflow=0, out_underflow=0, out_valid=0.
  - Sticky flags 0.
  - Reset asserted mid-operation abandons the op; no result is emitted and no flag is updated.
- mul_a and mul_b come straight from the operand registers; they change only when a new op is accepted.
- in_ready = (state==IDLE) | (state==DONE & out_ready). The signal is combinational.
- IDLE:
  - in_valid & in_ready: latch in_a, in_b, in_dest; counter=MUL_CYCLES-1; go to EXEC.
- EXEC:
  - counter!=0: decrement.
  - counter==0: latch mul_result, mul_overflow, mul_underflow into the out_* registers; go to DONE.
  - in_ready=0 throughout EXEC; in_valid is ignored.
- DONE:
  - out_valid=1; out_* registers held stable while out_ready=0.
  - out_ready & in_valid: new op accepted in the same cycle (back-to-back); go to EXEC.
  - out_ready & !in_valid: go to IDLE.
- Latency: op accepted at edge N gives out_valid=1 from edge N+MUL_CYCLES. Peak throughput is one op per MUL_CYCLES+1 cycles.
- Sticky flags:
  - At the EXEC->DONE capture edge: flag_overflow |= mul_overflow; flag_underflow |= mul_underflow.
  - flags_clear alone zeroes both flags.
  - flags_clear on the capture edge: clear is applied first, then the OR. The new op's flags survive.
- busy = (state != IDLE).
- No arithmetic is done here. The 32-bit result passes bit-exact from the multiplier, including NaN and infinity encodings.

Test Plan:
- Single op, MUL_CYCLES=2: in_a=0x40000000 (2.0), in_b=0x40400000 (3.0), in_dest=7 accepted at edge N -> out_valid at edge N+2, out_result=0x40C00000, out_dest=7, both flags 0, busy=1 from N until the handshake.
- Back-to-back: 0x3FC00000 x 0x3FC00000 and then 0x40000000 x 0x40000000, in_valid held high, out_ready=1 -> results 0x40100000 then 0x40800000, consecutive out_valid pulses 3 cycles apart, second op accepted on the DONE handshake cycle.
- Overflow: 0x7E800000 x 0x7E800000 -> out_overflow=1, flag_overflow=1. A later 2.0x3.0 leaves flag_overflow=1 with out_overflow=0. flags_clear then drops it to 0.
- Backpressure: out_ready low for 5 cycles in DONE -> out_result, out_dest and out_valid held stable, in_ready=0, in_valid ignored. out_ready rises -> handshake completes, return to IDLE.
- Reset mid-EXEC: reset for 1 cycle while counter=1 -> state IDLE, out_valid stays 0, mul_a=mul_b=0, sticky flags 0, in_ready=1 on the next cycle.
- MUL_CYCLES=1 plus flags_clear on the capture edge of an overflowing op -> out_valid one edge after accept, flag_overflow=1 after that edge.

Source files
------------

// File: rtl/fp_mult_sequencer.sv
// fp_mult_sequencer: issue/retire wrapper holding operands on an external FP multiplier for MUL_CYCLES cycles
module fp_mult_sequencer #(
    parameter int MUL_CYCLES = 2,
    parameter int DEST_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [DEST_W-1:0] in_dest,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [31:0]       mul_result,
    input  logic              mul_overflow,
    input  logic              mul_underflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_overflow,
    output logic              out_underflow,
    input  logic              flags_clear,
    output logic              flag_overflow,
    output logic              flag_underflow,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic accept, capture;
    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign capture   = (state == EXEC) & (cnt == 4'd0);
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? EXEC : IDLE;
            EXEC:    state_n = capture ? DONE : EXEC;
            DONE:    state_n = out_ready ? (in_valid ? EXEC : IDLE) : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            mul_a          <= 32'd0;
            mul_b          <= 32'd0;
            out_result     <= 32'd0;
            out_dest       <= '0;
            out_overflow   <= 1'b0;
            out_underflow  <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                mul_a    <= in_a;
                mul_b    <= in_b;
                out_dest <= in_dest;
                cnt      <= 4'(MUL_CYCLES - 1);
            end else if (state == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                out_result    <= mul_result;
                out_overflow  <= mul_overflow;
                out_underflow <= mul_underflow;
            end
            // clear takes effect before the newly captured op's flags are merged
            flag_overflow  <= (flag_overflow & ~flags_clear) | (capture & mul_overflow);
            flag_underflow <= (flag_underflow & ~flags_clear) | (capture & mul_underflow);
        end
    end
endmodule

// File: tb/tb_fp_mult_sequencer.sv
// tb_fp_mult_sequencer: directed checks of the sequencer with MUL_CYCLES=2 and MUL_CYCLES=1
module tb_fp_mult_sequencer;
    logic clk = 0, reset = 1;
    logic in_valid = 0, in_valid1 = 0, out_ready = 1, flags_clear = 0, flags_clear1 = 0;
    logic [31:0] in_a = 0, in_b = 0;
    logic [4:0] in_dest = 0;
    logic in_ready, out_valid, out_overflow, out_underflow, flag_overflow, flag_underflow, busy;
    logic [31:0] mul_a, mul_b, mul_result, out_result;
    logic [4:0] out_dest;
    logic mul_overflow, mul_underflow;
    logic in_ready1, out_valid1, out_overflow1, out_underflow1, flag_overflow1, flag_underflow1, busy1;
    logic [31:0] mul_a1, mul_b1, mul_result1, out_result1;
    logic [4:0] out_dest1;
    logic mul_overflow1, mul_underflow1;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    function automatic logic [33:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return {2'b00, 32'h40C00000};
            {32'h3FC00000, 32'h3FC00000}: return {2'b00, 32'h40100000};
            {32'h40000000, 32'h40000000}: return {2'b00, 32'h40800000};
            {32'h7E800000, 32'h7E800000}: return {2'b10, 32'h7F800000};
            {32'h00800000, 32'h00800000}: return {2'b01, 32'h00000000};
            {32'h7FC00000, 32'h3F800000}: return {2'b00, 32'h7FC00000};
            default:                      return {2'b00, a ^ b};
        endcase
    endfunction

    assign {mul_overflow, mul_underflow, mul_result}    = mul_model(mul_a, mul_b);
    assign {mul_overflow1, mul_underflow1, mul_result1} = mul_model(mul_a1, mul_b1);

    fp_mult_sequencer #(.MUL_CYCLES(2), .DEST_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_dest(in_dest), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_overflow(mul_overflow), .mul_underflow(mul_underflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_dest(out_dest),
        .out_overflow(out_overflow), .out_underflow(out_underflow), .flags_clear(flags_clear),
        .flag_overflow(flag_overflow), .flag_underflow(flag_underflow), .busy(busy)
    );

    fp_mult_sequencer #(.MUL_CYCLES(1), .DEST_W(5)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_dest(in_dest), .mul_a(mul_a1), .mul_b(mul_b1),
        .mul_result(mul_result1), .mul_overflow(mul_overflow1), .mul_underflow(mul_underflow1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_result(out_result1), .out_dest(out_dest1),
        .out_overflow(out_overflow1), .out_underflow(out_underflow1), .flags_clear(flags_clear1),
        .flag_overflow(flag_overflow1), .flag_underflow(flag_underflow1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op0(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        int n = 0;
        in_a = a; in_b = b; in_dest = d; in_valid = 1;
        step();
        in_valid = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("op_done", out_valid, 1);
    endtask

    initial begin
        step(); step();
        reset = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_result", out_result, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {flag_overflow, flag_underflow}, 0);

        // single op with backpressure
        out_ready = 0;
        in_a = 32'h40000000; in_b = 32'h40400000; in_dest = 7; in_valid = 1;
        step();
        in_valid = 1; in_a = 32'h12345678; in_b = 32'h9ABCDEF0; in_dest = 3;
        chk("s_busy", busy, 1);
        chk("s_mul_a", mul_a, 32'h40000000);
        chk("s_mul_b", mul_b, 32'h40400000);
        chk("s_ready_exec", in_ready, 0);
        step();
        chk("s_n1_valid", out_valid, 0);
        step();
        chk("s_n2_valid", out_valid, 1);
        chk("s_result", out_result, 32'h40C00000);
        chk("s_dest", out_dest, 7);
        chk("s_flags", {out_overflow, out_underflow, flag_overflow, flag_underflow}, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_result", out_result, 32'h40C00000);
            chk("bp_dest", out_dest, 7);
            chk("bp_ready", in_ready, 0);
            chk("bp_mul_a", mul_a, 32'h40000000);
        end
        in_valid = 0; out_ready = 1;
        step();
        chk("bp_done_valid", out_valid, 0);
        chk("bp_done_busy", busy, 0);

        // back-to-back
        in_a = 32'h3FC00000; in_b = 32'h3FC00000; in_dest = 1; in_valid = 1;
        step();
        in_a = 32'h40000000; in_b = 32'h40000000; in_dest = 2;
        step();
        chk("bb_mid_valid", out_valid, 0);
        step();
        chk("bb1_valid", out_valid, 1);
        chk("bb1_result", out_result, 32'h40100000);
        chk("bb1_dest", out_dest, 1);
        chk("bb1_ready", in_ready, 1);
        step();
        in_valid = 0;
        chk("bb2_accept_valid", out_valid, 0);
        chk("bb2_mul_a", mul_a, 32'h40000000);
        chk("bb2_busy", busy, 1);
        step();
        chk("bb2_n1_valid", out_valid, 0);
        step();
        chk("bb2_valid", out_valid, 1);
        chk("bb2_result", out_result, 32'h40800000);
        chk("bb2_dest", out_dest, 2);
        step();
        chk("bb_idle", busy, 0);

        // overflow and sticky flags
        op0(32'h7E800000, 32'h7E800000, 4);
        chk("ov_result", out_result, 32'h7F800000);
        chk("ov_out", out_overflow, 1);
        chk("ov_flag", flag_overflow, 1);
        step();
        op0(32'h40000000, 32'h40400000, 5);
        chk("ov2_out", out_overflow, 0);
        chk("ov2_flag", flag_overflow, 1);
        step();
        flags_clear = 1;
        step();
        flags_clear = 0;
        chk("clr_flag", flag_overflow, 0);

        // underflow and NaN pass-through
        op0(32'h00800000, 32'h00800000, 6);
        chk("uf_out", out_underflow, 1);
        chk("uf_flag", flag_underflow, 1);
        chk("uf_oflag", flag_overflow, 0);
        step();
        op0(32'h7FC00000, 32'h3F800000, 31);
        chk("nan_result", out_result, 32'h7FC00000);
        chk("nan_dest", out_dest, 31);
        step();

        // reset while counter=1
        in_a = 32'h40000000; in_b = 32'h40400000; in_dest = 9; in_valid = 1;
        step();
        in_valid = 0; reset = 1;
        step();
        reset = 0;
        chk("mr_valid", out_valid, 0);
        chk("mr_mul_a", mul_a, 0);
        chk("mr_mul_b", mul_b, 0);
        chk("mr_flags", {flag_overflow, flag_underflow}, 0);
        chk("mr_ready", in_ready, 1);
        chk("mr_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_stay_idle", out_valid, 0);
        end

        // MUL_CYCLES=1 and clear on the capture edge
        in_a = 32'h7E800000; in_b = 32'h7E800000; in_dest = 8; in_valid1 = 1;
        step();
        in_valid1 = 0;
        chk("m1_accept_valid", out_valid1, 0);
        step();
        chk("m1_valid", out_valid1, 1);
        chk("m1_result", out_result1, 32'h7F800000);
        chk("m1_dest", out_dest1, 8);
        chk("m1_flag", flag_overflow1, 1);
        step();
        in_a = 32'h40000000; in_b = 32'h40400000; in_valid1 = 1;
        step();
        in_valid1 = 0; flags_clear1 = 1;
        step();
        flags_clear1 = 0;
        chk("m1c_valid", out_valid1, 1);
        chk("m1c_result", out_result1, 32'h40C00000);
        chk("m1c_flag", flag_overflow1, 0);
        step();
        in_a = 32'h7E800000; in_b = 32'h7E800000; in_valid1 = 1;
        step();
        in_valid1 = 0; flags_clear1 = 1;
        step();
        flags_clear1 = 0;
        chk("m1o_valid", out_valid1, 1);
        chk("m1o_out", out_overflow1, 1);
        chk("m1o_flag", flag_overflow1, 1);
        step();
        chk("m1_idle", busy1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
